uart_txrx_top: RTL and testbench
================================

Name: uart_txrx_top

Overview:
- Full-duplex 8N1 UART: a transmitter serialises a parallel byte onto `tx`; a receiver deserialises `rx` into a parallel byte.
- Sits between a byte-oriented host interface and the board serial pins.
- Block-level test connects `tx` to `rx` externally as loopback.
- Single clock domain; `rx` is asynchronous to it and synchronised internally.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- BAUD_RATE, 115200, serial bit rate.
- CLKS_PER_BIT, CLK_FREQ_HZ/BAUD_RATE (integer division = 434), clocks per serial bit. Must be >= 4.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `tx_start`  in  1  one-cycle request to send `tx_data`.
- `tx_data`  in  8  byte to transmit; sampled only on an accepted `tx_start`.
- `rx`  in  1  serial input; idle high.
- `tx`  out  1  serial output; idle high.
- `busy`  out  1  transmitter occupied.
- `rx_data`  out  8  last received byte.
- `valid_rx`  out  1  one-cycle pulse when a frame completes.
- `stop_error`  out  1  stop bit of the last frame sampled low.

Behaviour:
- Reset values: `tx`=1, `busy`=0, `rx_data`=0, `valid_rx`=0, `stop_error`=0. Both FSMs return to IDLE and all counters clear.
- Reset asserted mid-frame aborts the frame immediately; `tx` goes high at once.
- Frame format, LSB first:
  - start bit 0,
  - data bits 0..7,
  - stop bit 1.
  - Each bit lasts CLKS_PER_BIT clocks.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_start`=1 latches `tx_data` into a shift register → START. `busy`=1 from the next cycle.
  - `tx_data` may change freely after the accept cycle.
  - START/DATA/STOP each hold their bit for CLKS_PER_BIT clocks; DATA uses a 3-bit index 0..7.
  - STOP end → IDLE, `busy`=0. `tx_start` then becomes acceptable in that same IDLE cycle.
  - `tx_start` while `busy`=1 is ignored; no queueing.
  - Accept-to-stop-end duration: exactly 10*CLKS_PER_BIT clocks.
- RX input path: 2-flop synchroniser on `rx`; all RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a low synchronised `rx` → START and clears the bit counter.
  - START: at CLKS_PER_BIT/2 re-sample the line. Low → DATA and restart the counter. High → glitch, return to IDLE with no output.
  - DATA: sample every CLKS_PER_BIT clocks, i.e. at mid-bit; shift bits in LSB first; 8 samples → STOP.
  - STOP: sample at mid-bit. At that cycle, update `rx_data` with the assembled byte, set `stop_error` = NOT sampled bit, pulse `valid_rx` for exactly 1 clock, → IDLE.
- `valid_rx` pulses for every completed frame, including frames with a stop error.
- `rx_data` and `stop_error` hold until the next completed frame.
- TX and RX are independent; simultaneous activity is allowed.
- Loopback latency: `valid_rx` occurs about 9.5*CLKS_PER_BIT + 3 clocks after `tx_start` is accepted.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - An even-parity bit is inserted after data bit 7 on both TX and RX. Frame is 11 bits.
  - TX/RX FSMs gain a PARITY state.
  - An extra output `parity_error` (1 bit, reset 0) is updated and held alongside `stop_error`.
- Undefined: pure 8N1 as above; no `parity_error` port.

Decomposition:
- Package uart_pkg:
  - TX/RX state enum typedefs,
  - DATA_BITS=8,
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- Sub-module uart_rx: synchroniser, RX FSM and `rx_data`/`valid_rx`/`stop_error` registers.
- TX FSM lives in the top, which also instantiates uart_rx.

Test Plan:
- Reset: hold `rst`=1 for 50 ns → `tx`=1, `busy`=0, `valid_rx`=0, `rx_data`=0, `stop_error`=0.
- Loopback (`tx`→`rx`): send 8'hAA, 8'hCC, 8'h0F, 8'hF0 in turn, each via a 1-cycle `tx_start` then `tx_data` changed to 0 next cycle → per byte exactly one `valid_rx` pulse with matching `rx_data`, `stop_error`=0.
- TX timing, 8'hAA: `busy` high for 10*CLKS_PER_BIT clocks. `tx` sequence: 0, then 0,1,0,1,0,1,0,1, then 1, each bit CLKS_PER_BIT wide. `tx_start` pulsed mid-frame is ignored.
- Stop error: drive `rx` with 8'h55 frame whose stop bit is 0 → `valid_rx` pulse, `rx_data`=8'h55, `stop_error`=1. A following good frame clears `stop_error` to 0.
- Glitch: `rx` low for CLKS_PER_BIT/4 clocks, then high → no `valid_rx`; `rx_data` unchanged.
- Reset mid-frame: assert `rst` during data bit 3 of a TX frame → `tx`=1 and `busy`=0 immediately. The next `tx_start` of 8'h3C is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the uart_txrx_top UART slice.
// Holds the TX/RX state encodings, the data width and the serial line levels
// used by both the transmitter (in the top) and the receiver (uart_rx).
// Optional build macro: UART_PARITY_EN adds a PARITY state to both FSMs.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser on the asynchronous serial input, RX FSM
// sampling each bit at mid-bit, and the held result registers.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_i            serial input (idle high, asynchronous to clk)
//   rx_data_o       last received byte, held until the next completed frame
//   valid_o         one-cycle pulse when a frame completes (good or not)
//   stop_error_o    stop bit of the last frame was sampled low
//   parity_error_o  even-parity mismatch of the last frame (UART_PARITY_EN only)
// Optional build macro: UART_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 valid_o,
`ifdef UART_PARITY_EN
  output logic                 parity_error_o,
`endif
  output logic                 stop_error_o
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic                 sync1_q, sync2_q;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 serr_q, serr_d;
`ifdef UART_PARITY_EN
  logic                 par_bit_q, par_bit_d;
  logic                 perr_q, perr_d;
`endif
  logic                 bit_done;

  assign bit_done = (cnt_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    serr_d  = serr_q;
`ifdef UART_PARITY_EN
    par_bit_d = par_bit_q;
    perr_d    = perr_q;
`endif
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (sync2_q == START_BIT) state_d = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit in: a short low pulse is a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = (sync2_q == START_BIT) ? RX_DATA : RX_IDLE;
        end
      end
      RX_DATA: begin
        // Counter restarted at mid start bit, so each wrap lands mid-bit.
        if (bit_done) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[DATA_BITS-1:1]};
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_bit_d = sync2_q;
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (bit_done) begin
          cnt_d   = '0;
          data_d  = sh_q;
          serr_d  = (sync2_q != STOP_BIT);
          valid_d = 1'b1;
`ifdef UART_PARITY_EN
          perr_d  = par_bit_q ^ (^sh_q);
`endif
          state_d = RX_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      serr_q  <= serr_d;
`ifdef UART_PARITY_EN
      par_bit_q <= par_bit_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign rx_data_o    = data_q;
  assign valid_o      = valid_q;
  assign stop_error_o = serr_q;
`ifdef UART_PARITY_EN
  assign parity_error_o = perr_q;
`endif

endmodule

// File: rtl/uart_txrx_top.sv
// Full-duplex 8N1 UART: TX FSM serialising a byte onto tx, plus the uart_rx
// receiver deserialising rx. Single clock domain; rx is synchronised inside.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tx_start      one-cycle send request (ignored while busy)
//   tx_data       byte to send, sampled only on an accepted tx_start
//   rx            serial input (idle high)
//   tx            serial output (idle high)
//   busy          transmitter occupied
//   rx_data       last received byte
//   valid_rx      one-cycle pulse per completed frame
//   stop_error    stop bit of the last frame sampled low
//   parity_error  even-parity error of the last frame (UART_PARITY_EN only)
// Optional build macro: UART_PARITY_EN (adds an even-parity bit, 11-bit frame).
module uart_txrx_top
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx,
  output logic                 tx,
  output logic                 busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid_rx,
`ifdef UART_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 stop_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
`endif
  logic                 bit_done;

  assign bit_done = (cnt_q == BIT_LAST);

  // tx_d is the level of the bit about to start, so the pin is registered
  // and changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == TX_IDLE || bit_done) ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      TX_IDLE: begin
        tx_d = IDLE_LEVEL;
        if (tx_start) begin
          sh_d    = tx_data;
          state_d = TX_START;
          tx_d    = START_BIT;
`ifdef UART_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      TX_START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = TX_DATA;
          tx_d    = sh_q[0];
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          sh_d = sh_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = TX_PARITY;
            tx_d    = par_q;
`else
            state_d = TX_STOP;
            tx_d    = STOP_BIT;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = sh_q[1];
          end
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (bit_done) begin
          state_d = TX_STOP;
          tx_d    = STOP_BIT;
        end
      end
`endif
      TX_STOP: begin
        if (bit_done) begin
          state_d = TX_IDLE;
          tx_d    = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = TX_IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= IDLE_LEVEL;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != TX_IDLE);

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .rx_i          (rx),
    .rx_data_o     (rx_data),
    .valid_o       (valid_rx),
`ifdef UART_PARITY_EN
    .parity_error_o(parity_error),
`endif
    .stop_error_o  (stop_error)
  );

endmodule

// File: tb/tb_uart_txrx_top.sv
module tb_uart_txrx_top;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 100000;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b1;
  logic       rx_w, tx_w, busy, valid_rx, stop_error;
  logic [7:0] rx_data;
`ifdef UART_PARITY_EN
  logic       parity_error;
`endif

  assign rx_w = loop_en ? tx_w : rx_drv;

  always #5 clk = ~clk;

  uart_txrx_top #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD_RATE  (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .rx        (rx_w),
    .tx        (tx_w),
    .busy      (busy),
    .rx_data   (rx_data),
    .valid_rx  (valid_rx),
`ifdef UART_PARITY_EN
    .parity_error(parity_error),
`endif
    .stop_error(stop_error)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int rx_cnt = 0;

  // Count frame-complete pulses seen by the host side.
  always @(negedge clk) if (valid_rx) rx_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Line levels of one frame, bit 0 first on the wire.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic stop);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef UART_PARITY_EN
    f[9]  = ^b;
    f[10] = stop;
`else
    f[9]  = stop;
`endif
    return f;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 2 * NBITS * CPB && busy; i++) @(negedge clk);
    chk("busy_drop", busy, 1'b0);
  endtask

  task automatic wait_rx(input int prev);
    for (int i = 0; i < 12 * CPB && rx_cnt == prev; i++) @(negedge clk);
    chk("rx_pulse", rx_cnt, prev + 1);
  endtask

  task automatic check_result(input string tag, input logic [7:0] b, input logic serr);
    chk({tag, "_data"}, rx_data, b);
    chk({tag, "_stop_err"}, stop_error, serr);
`ifdef UART_PARITY_EN
    chk({tag, "_par_err"}, parity_error, 1'b0);
`endif
  endtask

  // Loopback send; optionally checks the wire pattern, busy length and that
  // a mid-frame tx_start is ignored.
  task automatic send_lb(input logic [7:0] b, input bit timing);
    int prev, busy_cnt;
    logic [10:0] f;
    loop_en = 1'b1;
    @(negedge clk);
    wait_idle();
    prev = rx_cnt;
    f = frame_bits(b, 1'b1);
    tx_start = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    if (timing) begin
      busy_cnt = 0;
      for (int i = 0; i < NBITS * CPB + 4; i++) begin
        if (busy) busy_cnt++;
        if (i < NBITS * CPB && (i % CPB) == CPB / 2)
          chk($sformatf("tx_bit%0d", i / CPB), tx_w, f[i / CPB]);
        if (i == 3 * CPB + 3) begin
          tx_start = 1'b1;
          tx_data  = 8'h00;
        end else begin
          tx_start = 1'b0;
        end
        @(negedge clk);
      end
      chk("busy_len", busy_cnt, NBITS * CPB);
    end
    wait_rx(prev);
    check_result("lb", b, 1'b0);
    wait_idle();
    repeat (CPB) @(negedge clk);
    chk("lb_one_pulse", rx_cnt, prev + 1);
  endtask

  // Drive a frame straight onto rx, followed by two idle bit times.
  task automatic drive_frame(input logic [7:0] b, input logic stop);
    logic [10:0] f;
    int prev;
    loop_en = 1'b0;
    prev = rx_cnt;
    f = frame_bits(b, stop);
    @(negedge clk);
    for (int k = 0; k < NBITS; k++) begin
      rx_drv = f[k];
      repeat (CPB) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    wait_rx(prev);
    check_result("man", b, ~stop);
    chk("man_one_pulse", rx_cnt, prev + 1);
  endtask

  initial begin
    logic [7:0] last;
    logic [7:0] rb;
    logic       rs;
    int         prev;

    // Reset state
    rst = 1'b1;
    #50;
    chk("rst_tx", tx_w, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", valid_rx, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_stop_err", stop_error, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Wire timing on 8'hAA, then plain loopback of the directed bytes
    send_lb(8'hAA, 1'b1);
    send_lb(8'hCC, 1'b0);
    send_lb(8'h0F, 1'b0);
    send_lb(8'hF0, 1'b0);

    // Stop error, then a good frame clears it
    drive_frame(8'h55, 1'b0);
    drive_frame(8'hA3, 1'b1);

    // Glitch on rx shorter than half a bit
    last = rx_data;
    prev = rx_cnt;
    loop_en = 1'b0;
    @(negedge clk);
    rx_drv = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_no_pulse", rx_cnt, prev);
    chk("glitch_data_held", rx_data, last);

    // Reset in the middle of data bit 3
    loop_en = 1'b1;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h96;
    @(negedge clk);
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx_w, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_valid", valid_rx, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_lb(8'h3C, 1'b0);

    // Randomized loopback and directly driven frames
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_lb(rb, n == 0);
    end
    for (int n = 0; n < 4; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      drive_frame(rb, rs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
